// File: rtl/fft8_posit_sched.sv
// rtl/fft8_posit_sched.sv - 8-point radix-2 FFT scheduler driving an external posit butterfly
module fft8_posit_sched #(
    parameter int BF_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] bf_num1,
    output logic [31:0] bf_num2,
    output logic [2:0]  bf_twiddle,
    output logic        bf_valid,
    input  logic [31:0] bf_result1,
    input  logic [31:0] bf_result2
);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, UNLOAD} state_t;

    state_t      state, state_nx;
    logic [2:0]  cnt;
    logic [1:0]  stage;
    logic [1:0]  bfk;
    logic [1:0]  wr_cnt;
    logic        done_r;
    logic [31:0] mem [8];

    logic [2:0]        tag_a [BF_LAT];
    logic [2:0]        tag_b [BF_LAT];
    logic [BF_LAT-1:0] tag_v;

    logic [2:0] a_idx, b_idx, tw;
    logic       in_hs, out_hs, issue, wr_en;

    assign in_hs  = (state == LOAD) && in_valid;
    assign out_hs = (state == UNLOAD) && out_ready;
    assign issue  = (state == ISSUE);
    assign wr_en  = tag_v[BF_LAT-1];

    // Butterfly addressing for stage s, index k: pairs span 1<<s apart, twiddle j<<(2-s)
    always_comb begin
        a_idx = '0;
        b_idx = '0;
        tw    = '0;
        case (stage)
            2'd0: begin
                a_idx = {bfk, 1'b0};
                b_idx = {bfk, 1'b1};
            end
            2'd1: begin
                a_idx = {bfk[1], 1'b0, bfk[0]};
                b_idx = {bfk[1], 1'b1, bfk[0]};
                tw    = {1'b0, bfk[0], 1'b0};
            end
            default: begin
                a_idx = {1'b0, bfk};
                b_idx = {1'b1, bfk};
                tw    = {1'b0, bfk};
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start && !done_r) state_nx = LOAD;
            LOAD:   if (in_valid && cnt == 3'd7) state_nx = ISSUE;
            ISSUE:  if (bfk == 2'd3) state_nx = DRAIN;
            DRAIN:  if (wr_en && wr_cnt == 2'd3) state_nx = (stage == 2'd2) ? UNLOAD : ISSUE;
            UNLOAD: if (out_ready && cnt == 3'd7) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            stage  <= '0;
            bfk    <= '0;
            wr_cnt <= '0;
            done_r <= 1'b0;
            tag_v  <= '0;
        end else begin
            state  <= state_nx;
            done_r <= out_hs && (cnt == 3'd7);
            if (in_hs || out_hs) cnt <= cnt + 3'd1;
            if (issue) bfk <= bfk + 2'd1;
            if (wr_en) wr_cnt <= wr_cnt + 2'd1;
            if (state == DRAIN && state_nx != DRAIN)
                stage <= (stage == 2'd2) ? 2'd0 : stage + 2'd1;
            for (int i = BF_LAT - 1; i > 0; i--) tag_v[i] <= tag_v[i-1];
            tag_v[0] <= issue;
        end
    end

    // Addresses travel with the valid bit; only tag_v needs reset to squash in-flight writes
    always_ff @(posedge clk) begin
        for (int i = BF_LAT - 1; i > 0; i--) begin
            tag_a[i] <= tag_a[i-1];
            tag_b[i] <= tag_b[i-1];
        end
        tag_a[0] <= a_idx;
        tag_b[0] <= b_idx;
        if (in_hs) mem[{cnt[0], cnt[1], cnt[2]}] <= in_data;
        if (wr_en) begin
            mem[tag_a[BF_LAT-1]] <= bf_result1;
            mem[tag_b[BF_LAT-1]] <= bf_result2;
        end
    end

    assign busy       = (state != IDLE);
    assign done       = done_r;
    assign in_ready   = (state == LOAD);
    assign out_valid  = (state == UNLOAD);
    assign out_data   = mem[cnt];
    assign bf_valid   = issue;
    assign bf_num1    = mem[a_idx];
    assign bf_num2    = mem[b_idx];
    assign bf_twiddle = issue ? tw : 3'd0;

endmodule

// File: tb/tb_fft8_posit_sched.sv
// tb/tb_fft8_posit_sched.sv - directed bench for fft8_posit_sched at BF_LAT 1 and 6
module tb_fft8_posit_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, in_valid, out_ready, sel, identity;
    logic [31:0] in_data;

    logic        busy1, done1, in_ready1, out_valid1, bf_valid1;
    logic [31:0] out_data1, bf_num1_1, bf_num2_1, bf_r1_1, bf_r2_1;
    logic [2:0]  bf_tw1;
    logic        busy6, done6, in_ready6, out_valid6, bf_valid6;
    logic [31:0] out_data6, bf_num1_6, bf_num2_6, bf_r1_6, bf_r2_6;
    logic [2:0]  bf_tw6;

    logic        s_busy, s_done, s_in_ready, s_out_valid, s_bf_valid;
    logic [31:0] s_out_data, s_num1, s_num2;
    logic [2:0]  s_tw;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fft8_posit_sched #(.BF_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .busy(busy1), .done(done1),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .bf_num1(bf_num1_1), .bf_num2(bf_num2_1), .bf_twiddle(bf_tw1), .bf_valid(bf_valid1),
        .bf_result1(bf_r1_1), .bf_result2(bf_r2_1)
    );

    fft8_posit_sched #(.BF_LAT(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .busy(busy6), .done(done6),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready6),
        .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready),
        .bf_num1(bf_num1_6), .bf_num2(bf_num2_6), .bf_twiddle(bf_tw6), .bf_valid(bf_valid6),
        .bf_result1(bf_r1_6), .bf_result2(bf_r2_6)
    );

    assign s_busy      = sel ? busy6 : busy1;
    assign s_done      = sel ? done6 : done1;
    assign s_in_ready  = sel ? in_ready6 : in_ready1;
    assign s_out_valid = sel ? out_valid6 : out_valid1;
    assign s_out_data  = sel ? out_data6 : out_data1;
    assign s_bf_valid  = sel ? bf_valid6 : bf_valid1;
    assign s_num1      = sel ? bf_num1_6 : bf_num1_1;
    assign s_num2      = sel ? bf_num2_6 : bf_num2_1;
    assign s_tw        = sel ? bf_tw6 : bf_tw1;

    // Complex sample = {posit16 real, posit16 imag}, es=1; only small integers are modelled
    function automatic int dec(input logic [15:0] p);
        case (p)
            16'h0000: return 0;
            16'h4000: return 1;
            16'h5000: return 2;
            16'h6000: return 4;
            16'h6800: return 8;
            16'hC000: return -1;
            16'hB000: return -2;
            16'hA000: return -4;
            16'h9800: return -8;
            default:  return 1000;
        endcase
    endfunction

    function automatic logic [15:0] enc(input int v);
        case (v)
            0:  return 16'h0000;
            1:  return 16'h4000;
            2:  return 16'h5000;
            4:  return 16'h6000;
            8:  return 16'h6800;
            -1: return 16'hC000;
            -2: return 16'hB000;
            -4: return 16'hA000;
            -8: return 16'h9800;
            default: return 16'h8000;
        endcase
    endfunction

    function automatic logic [63:0] bfly(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] t, input logic idm);
        int ar, ai, br, bi, wr, wi;
        if (idm) return {x, y};
        ar = dec(x[31:16]); ai = dec(x[15:0]);
        br = dec(y[31:16]); bi = dec(y[15:0]);
        if (br == 0 && bi == 0) begin wr = 0; wi = 0; end
        else if (t == 3'd0) begin wr = br; wi = bi; end
        else if (t == 3'd2) begin wr = bi; wi = -br; end
        else begin wr = 1000; wi = 1000; end
        return {enc(ar + wr), enc(ai + wi), enc(ar - wr), enc(ai - wi)};
    endfunction

    logic [63:0] p1 [1];
    logic [63:0] p6 [6];
    always @(posedge clk) begin
        p1[0] <= bfly(bf_num1_1, bf_num2_1, bf_tw1, identity);
        for (int i = 5; i > 0; i--) p6[i] <= p6[i-1];
        p6[0] <= bfly(bf_num1_6, bf_num2_6, bf_tw6, identity);
    end
    assign bf_r1_1 = p1[0][63:32];
    assign bf_r2_1 = p1[0][31:0];
    assign bf_r1_6 = p6[5][63:32];
    assign bf_r2_6 = p6[5][31:0];

    logic [31:0] vin [8];
    logic [31:0] vexp [8];
    logic [8:0]  sched [12];
    logic [8:0]  exp_sched [12];
    int          nlog;
    int          cyc;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic run_load(input int gap);
        int w;
        for (int i = 0; i < 8; i++) begin
            if (gap != 0 && (i % 2) == 1) begin
                in_valid = 1'b0;
                step;
            end
            in_data  = vin[i];
            in_valid = 1'b1;
            w = 0;
            while (!s_in_ready && w < 20) begin step; w++; end
            if (w >= 20) chk("load_timeout", 32'(w), 32'd0);
            step;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_compute(input int poke);
        cyc  = 0;
        nlog = 0;
        while (!s_out_valid && cyc < 200) begin
            if (s_bf_valid && nlog < 12) begin
                sched[nlog] = {s_num1[2:0], s_num2[2:0], s_tw};
                nlog++;
            end
            start = (poke != 0 && cyc == 1);
            step;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic run_unload(input int bp);
        int n, c;
        logic [3:0] pat;
        pat = (bp != 0) ? 4'b1001 : 4'b1111;
        n = 0;
        c = 0;
        while (n < 8 && c < 200) begin
            out_ready = pat[c % 4];
            if (s_out_valid) begin
                if (out_ready) begin
                    chk($sformatf("out_data[%0d]", n), s_out_data, vexp[n]);
                    n++;
                end else begin
                    chk($sformatf("out_hold[%0d]", n), s_out_data, vexp[n]);
                end
            end
            step;
            c++;
        end
        out_ready = 1'b0;
        if (n < 8) chk("unload_timeout", 32'(n), 32'd8);
    endtask

    task automatic check_done;
        chk("done_pulse", {31'd0, s_done}, 32'd1);
        chk("busy_at_done", {31'd0, s_busy}, 32'd0);
    endtask

    initial begin
        int icnt, w;
        start = 0; in_valid = 0; out_ready = 0; in_data = '0; sel = 0; identity = 0;
        exp_sched = '{9'o010, 9'o230, 9'o450, 9'o670, 9'o020, 9'o132, 9'o460, 9'o572,
                      9'o040, 9'o151, 9'o262, 9'o373};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {30'd0, busy1, busy6}, 32'd0);
        chk("rst_done", {30'd0, done1, done6}, 32'd0);
        chk("rst_in_ready", {30'd0, in_ready1, in_ready6}, 32'd0);
        chk("rst_out_valid", {30'd0, out_valid1, out_valid6}, 32'd0);
        chk("rst_bf_valid", {30'd0, bf_valid1, bf_valid6}, 32'd0);
        chk("rst_twiddle", {26'd0, bf_tw1, bf_tw6}, 32'd0);
        rst_n = 1'b1;
        step;

        // Schedule: pass-through butterfly, each slot loaded with its own address
        identity = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vin[i]  = 32'hA000_0000 | 32'({i[0], i[1], i[2]});
            vexp[i] = 32'hA000_0000 | 32'(i);
        end
        do_start;
        chk("load_busy", {31'd0, s_busy}, 32'd1);
        chk("load_in_ready", {31'd0, s_in_ready}, 32'd1);
        run_load(0);
        run_compute(0);
        chk("sched_cycles_lat1", 32'(cyc), 32'd15);
        chk("sched_issues", 32'(nlog), 32'd12);
        for (int i = 0; i < 12; i++) chk($sformatf("sched[%0d]", i), {23'd0, sched[i]}, {23'd0, exp_sched[i]});
        run_unload(0);
        check_done;
        step;
        chk("done_one_cycle", {31'd0, s_done}, 32'd0);

        // Impulse at x[0], input gaps, out_ready 1,0,0,1, start poked during ISSUE
        identity = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vin[i]  = (i == 0) ? 32'h4000_0000 : 32'h0;
            vexp[i] = 32'h4000_0000;
        end
        do_start;
        run_load(1);
        run_compute(1);
        chk("impulse_cycles", 32'(cyc), 32'd15);
        run_unload(1);
        check_done;
        start = 1'b1;
        step;
        start = 1'b0;
        chk("start_in_done_ignored", {31'd0, s_busy}, 32'd0);
        chk("done_cleared", {31'd0, s_done}, 32'd0);

        // Impulse at x[4] -> (-1)^k; start accepted on the cycle after done
        for (int i = 0; i < 8; i++) begin
            vin[i]  = (i == 4) ? 32'h4000_0000 : 32'h0;
            vexp[i] = (i % 2 == 0) ? 32'h4000_0000 : 32'hC000_0000;
        end
        do_start;
        chk("start_after_done", {31'd0, s_busy}, 32'd1);
        run_load(0);
        run_compute(0);
        chk("alt_cycles", 32'(cyc), 32'd15);
        run_unload(0);
        check_done;
        step;

        // DC on the BF_LAT=6 instance
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vin[i]  = 32'h4000_0000;
            vexp[i] = (i == 0) ? 32'h6800_0000 : 32'h0;
        end
        do_start;
        run_load(1);
        run_compute(0);
        chk("dc_cycles_lat6", 32'(cyc), 32'd30);
        run_unload(1);
        check_done;
        step;

        // Reset in the middle of stage-1 drain, then a clean impulse run
        for (int i = 0; i < 8; i++) begin
            vin[i]  = (i == 0) ? 32'h4000_0000 : 32'h0;
            vexp[i] = 32'h4000_0000;
        end
        do_start;
        run_load(0);
        icnt = 0;
        w = 0;
        while (icnt < 8 && w < 100) begin
            if (s_bf_valid) icnt++;
            step;
            w++;
        end
        chk("drain_reached", {31'd0, s_bf_valid}, 32'd0);
        chk("drain_busy", {31'd0, s_busy}, 32'd1);
        step;
        step;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, s_busy}, 32'd0);
        chk("async_rst_bf_valid", {31'd0, s_bf_valid}, 32'd0);
        step;
        chk("rst_idle_busy", {31'd0, s_busy}, 32'd0);
        chk("rst_idle_twiddle", {29'd0, s_tw}, 32'd0);
        rst_n = 1'b1;
        step;
        do_start;
        run_load(0);
        run_compute(0);
        chk("post_rst_cycles", 32'(cyc), 32'd30);
        run_unload(0);
        check_done;
        step;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
